// File: rtl/normalise_sum_pipe.sv
// rtl/normalise_sum_pipe.sv - post-add normalisation stage with a 2-deep valid/ready pipeline
module normalise_sum_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SUM_W = MAN_W + 5,
  parameter int TAG_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             idle_in,
  input  logic [EXP_W+MAN_W:0]   sout_in,
  input  logic [1:0]             mode_in,
  input  logic                   operation_in,
  input  logic                   natlog_in,
  input  logic [SUM_W-1:0]       sum_in,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             idle_out,
  output logic [EXP_W+MAN_W:0]   sout_out,
  output logic [1:0]             mode_out,
  output logic                   operation_out,
  output logic                   natlog_out,
  output logic [SUM_W-1:0]       sum_out,
  output logic [TAG_W-1:0]       tag_out,
  output logic                   zero_flag,
  output logic                   uflow_flag,
  output logic                   oflow_flag
);

  localparam int LZ_W = $clog2(MAN_W + 1);
  localparam logic [1:0] PUT_IDLE = 2'b10;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  // Stage 1 registers
  logic                 r1_valid;
  logic [1:0]           r1_idle;
  logic [EXP_W+MAN_W:0] r1_sout;
  logic [1:0]           r1_mode;
  logic                 r1_operation;
  logic                 r1_natlog;
  logic [SUM_W-1:0]     r1_sum;
  logic [TAG_W-1:0]     r1_tag;
  logic                 r1_carry;
  logic [LZ_W-1:0]      r1_lz;
  logic                 r1_iszero;

  // Stage 2 registers (drive the outputs directly)
  logic                 r2_valid;
  logic [1:0]           r2_idle;
  logic [EXP_W+MAN_W:0] r2_sout;
  logic [1:0]           r2_mode;
  logic                 r2_operation;
  logic                 r2_natlog;
  logic [SUM_W-1:0]     r2_sum;
  logic [TAG_W-1:0]     r2_tag;
  logic                 r2_zero;
  logic                 r2_uflow;
  logic                 r2_oflow;

  logic                 w_s2_advance;
  logic                 w_s1_load;
  logic [LZ_W-1:0]      w_lz;
  logic                 w_found;
  logic                 w_iszero;

  // Stage 2 can take a beat when it is empty or its beat is leaving
  assign w_s2_advance = !r2_valid || out_ready;
  assign in_ready     = !r1_valid || w_s2_advance;
  assign w_s1_load    = in_valid && in_ready;
  assign w_iszero     = (sum_in[SUM_W-2:3] == '0) && !sum_in[SUM_W-1];

  // Leading-zero count of the hidden bit plus mantissa bits; an all-zero field clamps to MAN_W
  always_comb begin
    w_lz    = LZ_W'(MAN_W);
    w_found = 1'b0;
    for (int i = SUM_W - 2; i >= 3; i--) begin
      if (!w_found && sum_in[i]) begin
        w_lz    = LZ_W'(SUM_W - 2 - i);
        w_found = 1'b1;
      end
    end
  end

  // Stage 1: capture the beat with its carry, shift count and zero detect
  always_ff @(posedge clock) begin
    if (reset) begin
      r1_valid     <= 1'b0;
      r1_idle      <= '0;
      r1_sout      <= '0;
      r1_mode      <= '0;
      r1_operation <= 1'b0;
      r1_natlog    <= 1'b0;
      r1_sum       <= '0;
      r1_tag       <= '0;
      r1_carry     <= 1'b0;
      r1_lz        <= '0;
      r1_iszero    <= 1'b0;
    end else if (in_ready) begin
      r1_valid <= in_valid;
      if (w_s1_load) begin
        r1_idle      <= idle_in;
        r1_sout      <= sout_in;
        r1_mode      <= mode_in;
        r1_operation <= operation_in;
        r1_natlog    <= natlog_in;
        r1_sum       <= sum_in;
        r1_tag       <= tag_in;
        r1_carry     <= sum_in[SUM_W-1];
        r1_lz        <= w_lz;
        r1_iszero    <= w_iszero;
      end
    end
  end

  logic                 w_sign;
  logic [EXP_W-1:0]     w_exp;
  logic [MAN_W-1:0]     w_man;
  logic [EXP_W:0]       w_exp_inc;
  logic [EXP_W:0]       w_exp_dec;
  logic [SUM_W-1:0]     w_sum_rsh;
  logic [SUM_W-1:0]     w_sum_lsh;
  logic [EXP_W+MAN_W:0] w_sout_n;
  logic [SUM_W-1:0]     w_sum_n;
  logic                 w_zero_n;
  logic                 w_uflow_n;
  logic                 w_oflow_n;

  assign w_sign    = r1_sout[EXP_W+MAN_W];
  assign w_exp     = r1_sout[MAN_W +: EXP_W];
  assign w_man     = r1_sout[MAN_W-1:0];
  // One extra bit so the increment can exceed all-ones and the decrement can go negative
  assign w_exp_inc = {1'b0, w_exp} + (EXP_W+1)'(1);
  assign w_exp_dec = {1'b0, w_exp} - (EXP_W+1)'(r1_lz);
  // Right shift on carry keeps the dropped bit as sticky in bit 0
  assign w_sum_rsh = {1'b0, r1_sum[SUM_W-1:2], r1_sum[1] | r1_sum[0]};
  assign w_sum_lsh = r1_sum << r1_lz;

  // Stage 2 datapath: apply carry, zero, left-normalise and the exception flushes
  always_comb begin
    w_sout_n  = r1_sout;
    w_sum_n   = r1_sum;
    w_zero_n  = 1'b0;
    w_uflow_n = 1'b0;
    w_oflow_n = 1'b0;
    if (r1_idle == PUT_IDLE) begin
      w_sum_n = '0;
    end else if (r1_carry) begin
      if (w_exp_inc >= {1'b0, EXP_ONES}) begin
        w_sout_n  = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        w_sum_n   = '0;
        w_oflow_n = 1'b1;
      end else begin
        w_sout_n = {w_sign, w_exp_inc[EXP_W-1:0], w_man};
        w_sum_n  = w_sum_rsh;
      end
    end else if (r1_iszero) begin
      w_sout_n = {w_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      w_sum_n  = '0;
      w_zero_n = 1'b1;
    end else if (r1_lz != '0) begin
      if (w_exp_dec[EXP_W] || (w_exp_dec == '0)) begin
        w_sout_n  = {w_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        w_sum_n   = '0;
        w_uflow_n = 1'b1;
      end else begin
        w_sout_n = {w_sign, w_exp_dec[EXP_W-1:0], w_man};
        w_sum_n  = w_sum_lsh;
      end
    end
  end

  // Stage 2: hold the result while downstream stalls, otherwise take stage 1's beat
  always_ff @(posedge clock) begin
    if (reset) begin
      r2_valid     <= 1'b0;
      r2_idle      <= '0;
      r2_sout      <= '0;
      r2_mode      <= '0;
      r2_operation <= 1'b0;
      r2_natlog    <= 1'b0;
      r2_sum       <= '0;
      r2_tag       <= '0;
      r2_zero      <= 1'b0;
      r2_uflow     <= 1'b0;
      r2_oflow     <= 1'b0;
    end else if (w_s2_advance) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_idle      <= r1_idle;
        r2_sout      <= w_sout_n;
        r2_mode      <= r1_mode;
        r2_operation <= r1_operation;
        r2_natlog    <= r1_natlog;
        r2_sum       <= w_sum_n;
        r2_tag       <= r1_tag;
        r2_zero      <= w_zero_n;
        r2_uflow     <= w_uflow_n;
        r2_oflow     <= w_oflow_n;
      end
    end
  end

  assign out_valid     = r2_valid;
  assign idle_out      = r2_idle;
  assign sout_out      = r2_sout;
  assign mode_out      = r2_mode;
  assign operation_out = r2_operation;
  assign natlog_out    = r2_natlog;
  assign sum_out       = r2_sum;
  assign tag_out       = r2_tag;
  assign zero_flag     = r2_zero;
  assign uflow_flag    = r2_uflow;
  assign oflow_flag    = r2_oflow;

endmodule
